// File: rtl/sev_seg_number_formatter.sv
// Converts a 16-bit value into four seven-segment patterns plus dots.
// Decimal uses double-dabble (one shift per clock); hex encodes nibbles directly.
module sev_seg_number_formatter #(
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        hex_mode,
  input  logic [3:0]  dot_mask,
  output logic        busy,
  output logic        done,
  output logic [6:0]  digit_0,
  output logic [6:0]  digit_1,
  output logic [6:0]  digit_2,
  output logic [6:0]  digit_3,
  output logic [3:0]  dots
);

  typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

  typedef struct packed {
    logic       hex;
    logic       ovf;
    logic [3:0] dots;
  } req_t;

  state_t          state, state_nxt;
  req_t            req_q;
  logic [15:0]     shreg, bcd, bcd_adj;
  logic [3:0]      cnt;
  logic [3:0][3:0] nib;
  logic [3:0][6:0] seg_nxt;
  logic            blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = hex_mode ? ENCODE : CONVERT;
      CONVERT: if (cnt == 4'd15) state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction on every BCD digit before each shift.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  // In hex mode shreg still holds the raw value; after 16 shifts it is zero
  // and bcd carries the decimal digits.
  assign nib = req_q.hex ? shreg : bcd;

  always_comb begin
    seg_nxt = '0;
    blank   = BLANK_LEADING_ZEROS;
    for (int i = 3; i >= 1; i--) begin
      blank      = blank && (nib[i] == 4'd0);
      seg_nxt[i] = blank ? 7'h00 : seg7(nib[i]);
    end
    seg_nxt[0] = seg7(nib[0]);
    if (req_q.ovf && !req_q.hex) seg_nxt = {4{7'h40}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      shreg   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      digit_0 <= '0;
      digit_1 <= '0;
      digit_2 <= '0;
      digit_3 <= '0;
      dots    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          req_q.hex  <= hex_mode;
          req_q.ovf  <= (value > 16'd9999);
          req_q.dots <= dot_mask;
          shreg      <= value;
          bcd        <= '0;
          cnt        <= '0;
        end
        CONVERT: begin
          {bcd, shreg} <= {bcd_adj[14:0], shreg, 1'b0};
          cnt          <= cnt + 4'd1;
        end
        ENCODE: begin
          digit_0 <= seg_nxt[0];
          digit_1 <= seg_nxt[1];
          digit_2 <= seg_nxt[2];
          digit_3 <= seg_nxt[3];
          dots    <= req_q.dots;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sev_seg_number_formatter.sv
// Randomized and directed checks of sev_seg_number_formatter against a
// division-based reference model; two instances cover both blanking settings.
module tb_sev_seg_number_formatter;
  logic        clk = 1'b0;
  logic        rst, start, hex_mode;
  logic [15:0] value;
  logic [3:0]  dot_mask;
  logic        busy, done, busy0, done0;
  logic [6:0]  d0, d1, d2, d3, e0, e1, e2, e3;
  logic [3:0]  dots, dots0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sev_seg_number_formatter #(.BLANK_LEADING_ZEROS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .hex_mode(hex_mode),
    .dot_mask(dot_mask), .busy(busy), .done(done), .digit_0(d0), .digit_1(d1),
    .digit_2(d2), .digit_3(d3), .dots(dots));

  sev_seg_number_formatter #(.BLANK_LEADING_ZEROS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .value(value), .hex_mode(hex_mode),
    .dot_mask(dot_mask), .busy(busy0), .done(done0), .digit_0(e0), .digit_1(e1),
    .digit_2(e2), .digit_3(e3), .dots(dots0));

  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected {digit_3, digit_2, digit_1, digit_0}.
  function automatic logic [27:0] model(input int v, input bit hx, input bit blz);
    int n[4];
    logic [6:0] p[4];
    int pw;
    bit blank;
    if (!hx && v > 9999) return {4{7'h40}};
    pw = 1;
    for (int i = 0; i < 4; i++) begin
      n[i] = hx ? ((v >> (4*i)) & 15) : ((v / pw) % 10);
      pw = pw * 10;
    end
    blank = blz;
    for (int i = 3; i >= 1; i--) begin
      blank = blank && (n[i] == 0);
      p[i]  = blank ? 7'h00 : seg(n[i]);
    end
    p[0] = seg(n[0]);
    return {p[3], p[2], p[1], p[0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [15:0] v, input bit hx, input logic [3:0] dm, input string name);
    int lat;
    logic [27:0] x1, x0;
    value = v; hex_mode = hx; dot_mask = dm; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick; lat++; end
    x1 = model(int'(v), hx, 1'b1);
    x0 = model(int'(v), hx, 1'b0);
    checks++;
    if (lat != (hx ? 1 : 17)) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, lat, hx ? 1 : 17); end
    checks++;
    if ({d3, d2, d1, d0} !== x1) begin failures++; $display("FAIL %s digits: got %h expected %h", name, {d3, d2, d1, d0}, x1); end
    checks++;
    if ({e3, e2, e1, e0} !== x0) begin failures++; $display("FAIL %s digits_noblank: got %h expected %h", name, {e3, e2, e1, e0}, x0); end
    checks++;
    if (dots !== dm) begin failures++; $display("FAIL %s dots: got %b expected %b", name, dots, dm); end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s done_width: got done=%b busy=%b expected 0 0", name, done, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; value = '0; hex_mode = 1'b0; dot_mask = '0;
    tick; tick;
    checks++;
    if ({d3, d2, d1, d0, dots, busy, done} !== 34'd0) begin failures++; $display("FAIL reset_init: got %h expected 0", {d3, d2, d1, d0, dots, busy, done}); end
    rst = 1'b1;
    tick;
    convert(16'h1234, 1'b1, 4'b1111, "pre_reset_hex");
    value = 16'd4321; hex_mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({d3, d2, d1, d0, dots, busy, done} !== 34'd0) begin failures++; $display("FAIL reset_async: got %h expected 0", {d3, d2, d1, d0, dots, busy, done}); end
    rst = 1'b1;
    repeat (5) tick;
    checks++;
    if ({d3, d2, d1, d0, dots, busy, done} !== 34'd0) begin failures++; $display("FAIL reset_idle: got %h expected 0", {d3, d2, d1, d0, dots, busy, done}); end
  endtask

  task automatic test_decimal_1234;
    int bad;
    value = 16'd1234; hex_mode = 1'b0; dot_mask = 4'b0100; start = 1'b1;
    tick;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i < 16) tick;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL dec1234_busy: got %0d bad cycles expected 0", bad); end
    tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL dec1234_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++;
    if ({d3, d2, d1, d0, dots} !== {7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100}) begin
      failures++; $display("FAIL dec1234_digits: got %h expected %h", {d3, d2, d1, d0, dots}, {7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0100});
    end
    tick;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL dec1234_pulse: got %b expected 0", done); end
  endtask

  task automatic test_blanking;
    convert(16'd7, 1'b0, 4'b0000, "dec7");
    checks++;
    if ({e3, e2, e1, e0} !== {7'h3F, 7'h3F, 7'h3F, 7'h07}) begin failures++; $display("FAIL dec7_noblank_const: got %h expected %h", {e3, e2, e1, e0}, {7'h3F, 7'h3F, 7'h3F, 7'h07}); end
    checks++;
    if ({d3, d2, d1, d0} !== {7'h00, 7'h00, 7'h00, 7'h07}) begin failures++; $display("FAIL dec7_blank_const: got %h expected %h", {d3, d2, d1, d0}, {7'h00, 7'h00, 7'h00, 7'h07}); end
    convert(16'd0, 1'b0, 4'b0001, "dec0");
    convert(16'd9999, 1'b0, 4'b1010, "dec9999");
    convert(16'd1005, 1'b0, 4'b0000, "dec1005");
  endtask

  task automatic test_overflow_hex;
    convert(16'd10000, 1'b0, 4'b0011, "dec10000");
    checks++;
    if ({d3, d2, d1, d0} !== {4{7'h40}}) begin failures++; $display("FAIL ovf_const: got %h expected %h", {d3, d2, d1, d0}, {4{7'h40}}); end
    convert(16'hFFFF, 1'b0, 4'b0000, "decFFFF");
    convert(16'hBEEF, 1'b1, 4'b0000, "hexBEEF");
    checks++;
    if ({d3, d2, d1, d0} !== {7'h7C, 7'h79, 7'h79, 7'h71}) begin failures++; $display("FAIL beef_const: got %h expected %h", {d3, d2, d1, d0}, {7'h7C, 7'h79, 7'h79, 7'h71}); end
    convert(16'h00A0, 1'b1, 4'b0000, "hex00A0");
    convert(16'h0000, 1'b1, 4'b1000, "hex0000");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      convert(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
    for (int i = 0; i < 12; i++)
      convert(16'($urandom_range(0, 9999)), 1'b0, 4'($urandom_range(0, 15)), "random_dec");
  endtask

  task automatic test_ignore_start;
    int lat;
    value = 16'd1234; hex_mode = 1'b0; dot_mask = 4'b0001; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    value = 16'd5678; hex_mode = 1'b1; dot_mask = 4'b1110; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin tick; lat++; end
    checks++;
    if (lat != 17) begin failures++; $display("FAIL ignore_latency: got %0d expected 17", lat); end
    checks++;
    if ({d3, d2, d1, d0, dots} !== {model(1234, 1'b0, 1'b1), 4'b0001}) begin
      failures++; $display("FAIL ignore_result: got %h expected %h", {d3, d2, d1, d0, dots}, {model(1234, 1'b0, 1'b1), 4'b0001});
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignore_requeue: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int gap;
    value = 16'd42; hex_mode = 1'b0; dot_mask = 4'b0000; start = 1'b1;
    tick;
    gap = 1;
    while (!done && gap < 40) begin tick; gap++; end
    for (int r = 0; r < 3; r++) begin
      tick;
      gap = 1;
      while (!done && gap < 40) begin tick; gap++; end
      checks++;
      if (gap != 18) begin failures++; $display("FAIL b2b_period: got %0d expected 18", gap); end
      checks++;
      if ({d3, d2, d1, d0} !== {7'h00, 7'h00, 7'h66, 7'h5B}) begin failures++; $display("FAIL b2b_digits: got %h expected %h", {d3, d2, d1, d0}, {7'h00, 7'h00, 7'h66, 7'h5B}); end
    end
    start = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_convert;
    int seen;
    value = 16'd8765; hex_mode = 1'b0; dot_mask = 4'b1111; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({d3, d2, d1, d0, dots, busy, done} !== 34'd0) begin failures++; $display("FAIL reset_mid: got %h expected 0", {d3, d2, d1, d0, dots, busy, done}); end
    rst = 1'b1;
    seen = 0;
    repeat (20) begin tick; if (done !== 1'b0 || busy !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_mid_nodone: got %0d active cycles expected 0", seen); end
    convert(16'd4321, 1'b0, 4'b0010, "after_reset");
  endtask

  initial begin
    test_reset;
    test_decimal_1234;
    test_blanking;
    test_overflow_hex;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_convert;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sev_seg_number_formatter.md
Name: sev_seg_number_formatter

Overview:
Upstream stage of sev_seg_displays_controller. It converts a 16-bit binary number into four seven-segment patterns plus dots, and drives that controller's digit_0..digit_3 and dots inputs directly.
- Decimal mode: iterative double-dabble conversion, one shift per clock.
- Hex mode: direct nibble encoding.
- Outputs are registered and change atomically, so the multiplexed display never shows a half-updated value.

Parameters:
BLANK_LEADING_ZEROS, 1, 1 = blank leading zero digits (digit_0 is never blanked); 0 = show all digits.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
start  input  1  request conversion of value; sampled only in IDLE
value  input  16  binary number to display
hex_mode  input  1  1 = hexadecimal, 0 = decimal; sampled with start
dot_mask  input  4  decimal points; bit i maps to digit i; sampled with start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are valid
digit_0  output  7  rightmost digit pattern; bit0 = segment a … bit6 = segment g; active-high
digit_1  output  7  pattern for digit 1
digit_2  output  7  pattern for digit 2
digit_3  output  7  leftmost digit pattern
dots  output  4  latched dot_mask

Behaviour:
- Reset (rst low, asynchronous): state IDLE; digit_0..3 = 7'h00 (blank); dots = 0; busy = 0; done = 0; internal shift and BCD registers cleared.
- States: IDLE, CONVERT, ENCODE.
- IDLE:
  - On a clock edge with start = 1, latch value, hex_mode and dot_mask.
  - busy goes 1.
  - Next state is CONVERT if decimal, ENCODE if hex.
- CONVERT (decimal only):
  - 4-bit counter, 16 iterations.
  - Each edge: every BCD nibble ≥ 5 gets +3, then {bcd[15:0], shreg[15:0]} shifts left by 1.
  - Done after exactly 16 edges, then go to ENCODE.
  - Any value ≥ 10000 sets an overflow flag at latch time.
- ENCODE (one edge):
  - Write all four digit outputs and dots together.
  - done = 1 for the following cycle; busy = 0; return to IDLE.
- Latency, start captured at edge k:
  - Decimal: outputs update at edge k+17.
  - Hex: outputs update at edge k+1.
  - done is high in the cycle after the update edge.
  - busy is high from edge k until the update edge.
- Encoding, nibble → pattern:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Overflow (decimal, value > 9999): all four digits = 7'h40 (dash). dots are still applied. No blanking.
- Leading-zero blanking (BLANK_LEADING_ZEROS = 1, both modes):
  - Scan from digit_3 downward; each zero nibble becomes 7'h00 until the first non-zero nibble.
  - digit_0 always shows its pattern, so value 0 displays "   0".
  - Dots are not blanked.
- start while busy: ignored. It is not queued, and latched inputs are unaffected.
- start held high continuously: a new conversion begins on the first edge back in IDLE (the cycle done is high). Back-to-back conversions therefore occur with no idle gap.
- Input changes during busy: no effect.
- Reset mid-conversion: conversion aborted, outputs blanked immediately (asynchronous), done not asserted.

Test Plan:
- Reset:
  - Assert rst low mid-operation → digits = 00, dots = 0, busy = 0, done = 0, with no clock edge needed.
  - Release rst and idle 5 cycles → outputs unchanged.
- Decimal 1234 with dot_mask = 4'b0100:
  - Pulse start → busy for 17 cycles.
  - digit_3..0 = 06, 5B, 4F, 66; dots = 0100.
  - done high exactly 1 cycle, at cycle 18.
- Leading-zero blanking:
  - Decimal 7 → 00, 00, 00, 07.
  - Decimal 0 → 00, 00, 00, 3F.
  - Decimal 9999 → 6F ×4.
  - With BLANK_LEADING_ZEROS = 0, decimal 7 → 3F, 3F, 3F, 07.
- Overflow and hex:
  - Decimal 10000 → 40 ×4.
  - Hex 16'hBEEF → 7C, 79, 79, 71, with done one cycle after the start edge.
  - Hex 16'h00A0 → 00, 00, 77, 3F.
- Handshake:
  - Pulse start with 1234, then start with 5678 at cycle 5 → second start ignored; result is 1234.
  - Hold start high with value 42 → repeated conversions with done every 18 cycles; outputs stable at 00, 00, 66, 5B.
- Reset during CONVERT at cycle 8 → outputs blank, no done pulse; a subsequent start converts correctly.
